// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg: ALU ctrl codes and MIPS opcode/funct constants shared with ALU.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_BNE     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1000;
  localparam logic [3:0] ALU_XOR     = 4'b1001;
  localparam logic [3:0] ALU_SLL     = 4'b1010;
  localparam logic [3:0] ALU_SRA     = 4'b1011;
  localparam logic [3:0] ALU_SRL     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  typedef enum logic [1:0] {
    IN1_RT   = 2'd0,
    IN1_SEXT = 2'd1,
    IN1_ZEXT = 2'd2
  } in1_sel_e;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_ctrl_dec: MIPS instruction -> ALU ctrl code and operands (comb).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_ctrl_dec
  import alu_pkg::*;
#(
  parameter int DW        = 32,
  parameter int ILLEGAL_Z = 1
) (
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs,
  input  logic [DW-1:0] rt,
  output logic [3:0]    ctrl,
  output logic [DW-1:0] in_0,
  output logic [DW-1:0] in_1,
  output logic          illegal
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        shift;
  in1_sel_e    in1_sel;
  logic        unused_reg_fields;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign shamt = instr[10:6];
  assign imm   = instr[15:0];
  // Register specifiers are resolved upstream; operands arrive already read.
  assign unused_reg_fields = ^instr[25:16];

  always_comb begin
    ctrl    = (ILLEGAL_Z != 0) ? ALU_ILLEGAL : ALU_ADD;
    illegal = 1'b1;
    shift   = 1'b0;
    in1_sel = IN1_RT;
    case (op)
      OP_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FN_ADD:  ctrl = ALU_ADD;
          FN_SUB:  ctrl = ALU_SUB;
          FN_AND:  ctrl = ALU_AND;
          FN_OR:   ctrl = ALU_OR;
          FN_XOR:  ctrl = ALU_XOR;
          FN_NOR:  ctrl = ALU_NOR;
          FN_SLT:  ctrl = ALU_SLT;
          FN_SLL:  begin ctrl = ALU_SLL; shift = 1'b1; end
          FN_SRL:  begin ctrl = ALU_SRL; shift = 1'b1; end
          FN_SRA:  begin ctrl = ALU_SRA; shift = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin illegal = 1'b0; ctrl = ALU_ADD; in1_sel = IN1_SEXT; end
      OP_SLTI: begin illegal = 1'b0; ctrl = ALU_SLT; in1_sel = IN1_SEXT; end
      OP_ANDI: begin illegal = 1'b0; ctrl = ALU_AND; in1_sel = IN1_ZEXT; end
      OP_ORI:  begin illegal = 1'b0; ctrl = ALU_OR;  in1_sel = IN1_ZEXT; end
      OP_XORI: begin illegal = 1'b0; ctrl = ALU_XOR; in1_sel = IN1_ZEXT; end
      OP_BEQ:  begin illegal = 1'b0; ctrl = ALU_SUB; end
      OP_BNE:  begin illegal = 1'b0; ctrl = ALU_BNE; end
      default: ;
    endcase
  end

  assign in_0 = shift ? {{(DW-5){1'b0}}, shamt} : rs;

  always_comb begin
    case (in1_sel)
      IN1_SEXT: in_1 = {{(DW-16){imm[15]}}, imm};
      IN1_ZEXT: in_1 = {{(DW-16){1'b0}}, imm};
      default:  in_1 = rt;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_stage: ID->EX issue register with one skid entry for the ALU.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW        = 32,
  parameter int ILLEGAL_Z = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [3:0]    ex_ctrl,
  output logic [DW-1:0] ex_in_0,
  output logic [DW-1:0] ex_in_1,
  output logic          ex_illegal
);

  logic [3:0]    dec_ctrl;
  logic [DW-1:0] dec_in_0, dec_in_1;
  logic          dec_illegal;

  alu_ctrl_dec #(.DW(DW), .ILLEGAL_Z(ILLEGAL_Z)) u_dec (
    .instr   (id_instr),
    .rs      (id_rs_data),
    .rt      (id_rt_data),
    .ctrl    (dec_ctrl),
    .in_0    (dec_in_0),
    .in_1    (dec_in_1),
    .illegal (dec_illegal)
  );

  logic          or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
  logic [3:0]    or_ctrl_q, or_ctrl_d, sk_ctrl_q, sk_ctrl_d;
  logic [DW-1:0] or_in_0_q, or_in_0_d, sk_in_0_q, sk_in_0_d;
  logic [DW-1:0] or_in_1_q, or_in_1_d, sk_in_1_q, sk_in_1_d;
  logic          or_ill_q, or_ill_d, sk_ill_q, sk_ill_d;
  logic          id_ready_q, id_ready_d;
  logic          id_fire, or_free;

  assign id_fire = id_valid & id_ready_q;
  assign or_free = ~or_valid_q | ex_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_ctrl_d  = or_ctrl_q;
    or_in_0_d  = or_in_0_q;
    or_in_1_d  = or_in_1_q;
    or_ill_d   = or_ill_q;
    sk_valid_d = sk_valid_q;
    sk_ctrl_d  = sk_ctrl_q;
    sk_in_0_d  = sk_in_0_q;
    sk_in_1_d  = sk_in_1_q;
    sk_ill_d   = sk_ill_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (or_free) begin
      if (sk_valid_q) begin
        // Older skid entry moves up first; a new word backfills the skid.
        or_valid_d = 1'b1;
        or_ctrl_d  = sk_ctrl_q;
        or_in_0_d  = sk_in_0_q;
        or_in_1_d  = sk_in_1_q;
        or_ill_d   = sk_ill_q;
        sk_valid_d = id_fire;
        if (id_fire) begin
          sk_ctrl_d = dec_ctrl;
          sk_in_0_d = dec_in_0;
          sk_in_1_d = dec_in_1;
          sk_ill_d  = dec_illegal;
        end
      end else begin
        or_valid_d = id_fire;
        if (id_fire) begin
          or_ctrl_d = dec_ctrl;
          or_in_0_d = dec_in_0;
          or_in_1_d = dec_in_1;
          or_ill_d  = dec_illegal;
        end
      end
    end else if (id_fire) begin
      sk_valid_d = 1'b1;
      sk_ctrl_d  = dec_ctrl;
      sk_in_0_d  = dec_in_0;
      sk_in_1_d  = dec_in_1;
      sk_ill_d   = dec_illegal;
    end
    id_ready_d = ~sk_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_ctrl_q  <= '0;
      or_in_0_q  <= '0;
      or_in_1_q  <= '0;
      or_ill_q   <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_ctrl_q  <= '0;
      sk_in_0_q  <= '0;
      sk_in_1_q  <= '0;
      sk_ill_q   <= 1'b0;
      id_ready_q <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_ctrl_q  <= or_ctrl_d;
      or_in_0_q  <= or_in_0_d;
      or_in_1_q  <= or_in_1_d;
      or_ill_q   <= or_ill_d;
      sk_valid_q <= sk_valid_d;
      sk_ctrl_q  <= sk_ctrl_d;
      sk_in_0_q  <= sk_in_0_d;
      sk_in_1_q  <= sk_in_1_d;
      sk_ill_q   <= sk_ill_d;
      id_ready_q <= id_ready_d;
    end
  end

  assign id_ready   = id_ready_q;
  assign ex_valid   = or_valid_q;
  assign ex_ctrl    = or_ctrl_q;
  assign ex_in_0    = or_in_0_q;
  assign ex_in_1    = or_in_1_q;
  assign ex_illegal = or_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_issue_stage: directed + throttled checks against a FIFO model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alu_issue_stage;

  localparam int DW = 32;

  logic          clk, rst_n, flush, id_valid, id_ready, ex_valid, ex_ready, ex_illegal;
  logic [31:0]   id_instr;
  logic [DW-1:0] id_rs_data, id_rt_data, ex_in_0, ex_in_1;
  logic [3:0]    ex_ctrl;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage #(.DW(DW), .ILLEGAL_Z(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_ctrl    (ex_ctrl),
    .ex_in_0    (ex_in_0),
    .ex_in_1    (ex_in_1),
    .ex_illegal (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  // Expected decode straight from the instruction-set table.
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt);
    exp_t e;
    logic [31:0] sx, zx, sh;
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    sh = {27'd0, ins[10:6]};
    e  = '{4'hF, rs, rt, 1'b1};
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: e = '{4'h2, rs, rt, 1'b0};
        6'h22: e = '{4'h6, rs, rt, 1'b0};
        6'h24: e = '{4'h0, rs, rt, 1'b0};
        6'h25: e = '{4'h1, rs, rt, 1'b0};
        6'h26: e = '{4'h9, rs, rt, 1'b0};
        6'h27: e = '{4'h8, rs, rt, 1'b0};
        6'h2A: e = '{4'h7, rs, rt, 1'b0};
        6'h00: e = '{4'hA, sh, rt, 1'b0};
        6'h02: e = '{4'hC, sh, rt, 1'b0};
        6'h03: e = '{4'hB, sh, rt, 1'b0};
        default: ;
      endcase
    end else begin
      case (ins[31:26])
        6'h08, 6'h23, 6'h2B: e = '{4'h2, rs, sx, 1'b0};
        6'h0A: e = '{4'h7, rs, sx, 1'b0};
        6'h0C: e = '{4'h0, rs, zx, 1'b0};
        6'h0D: e = '{4'h1, rs, zx, 1'b0};
        6'h0E: e = '{4'h9, rs, zx, 1'b0};
        6'h04: e = '{4'h6, rs, rt, 1'b0};
        6'h05: e = '{4'h3, rs, rt, 1'b0};
        default: ;
      endcase
    end
    return e;
  endfunction

  // Two-deep FIFO model: registered ready means "not full", and none in the first cycle out of reset.
  exp_t q[$];
  bit   armed;
  bit   m_in, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      armed = 1'b0;
    end else begin
      m_in  = id_valid && armed && (q.size() < 2);
      m_out = (q.size() > 0) && ex_ready;
      if (flush) q.delete();
      else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back(model_dec(id_instr, id_rs_data, id_rt_data));
      end
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_id_ready", {31'd0, id_ready}, {31'd0, armed && (q.size() < 2)});
      chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("m_ctrl", {28'd0, ex_ctrl}, {28'd0, q[0].ctrl});
        chk("m_in_0", ex_in_0, q[0].a);
        chk("m_in_1", ex_in_1, q[0].b);
        chk("m_illegal", {31'd0, ex_illegal}, {31'd0, q[0].ill});
      end
    end
  end

  // Called at posedge+1; leaves at posedge+1 after the word is accepted.
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bit rd, done;
    id_valid = 1'b1; id_instr = ins; id_rs_data = rs; id_rt_data = rt;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk) rd = id_ready;
      @(posedge clk); #1;
      if (rd) done = 1'b1;
    end
    id_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [3:0] ec, input logic [31:0] e0,
                       input logic [31:0] e1, input logic ei);
    id_valid = 1'b1; id_instr = ins; id_rs_data = rs; id_rt_data = rt;
    @(posedge clk); #1 id_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, ex_valid}, 32'd1);
    chk({nm, "_ctrl"}, {28'd0, ex_ctrl}, {28'd0, ec});
    chk({nm, "_in_0"}, ex_in_0, e0);
    chk({nm, "_in_1"}, ex_in_1, e1);
    chk({nm, "_illegal"}, {31'd0, ex_illegal}, {31'd0, ei});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h00, 6'h02, 6'h03, 6'h3F};
    logic [5:0] ops [10] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h23, 6'h2B,
                             6'h04, 6'h05, 6'h3F};
    logic [31:0] r;
    int idx;
    r   = $urandom;
    idx = $urandom_range(0, 20);
    if (idx < 11) begin
      r[31:26] = 6'h00;
      r[5:0]   = fns[idx];
    end else begin
      r[31:26] = ops[idx-11];
    end
    return r;
  endfunction

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_ADD  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_SUB  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22};
  localparam logic [31:0] I_OR   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
  localparam logic [31:0] I_SRA  = {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03};
  localparam logic [31:0] I_SLTI = {6'h0A, 5'd1, 5'd2, 16'hFFFF};
  localparam logic [31:0] I_ORI  = {6'h0D, 5'd1, 5'd2, 16'hFFFF};
  localparam logic [31:0] I_BNE  = {6'h05, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_ILL  = {6'h3F, 5'd1, 5'd2, 16'h1234};
  localparam logic [31:0] I_ILLF = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F};

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;

    // Decode sweep with EX always ready.
    issue("add",  I_ADD,  32'd5, 32'd7, 4'b0010, 32'd5, 32'd7, 1'b0);
    issue("sra",  I_SRA,  32'h1234, 32'hF000_0000, 4'b1011, 32'd4, 32'hF000_0000, 1'b0);
    issue("slti", I_SLTI, 32'd5, 32'd9, 4'b0111, 32'd5, 32'hFFFF_FFFF, 1'b0);
    issue("ori",  I_ORI,  32'd5, 32'd9, 4'b0001, 32'd5, 32'h0000_FFFF, 1'b0);
    issue("bne",  I_BNE,  32'd9, 32'd3, 4'b0011, 32'd9, 32'd3, 1'b0);
    issue("ill",  I_ILL,  32'hAA, 32'hBB, 4'b1111, 32'hAA, 32'hBB, 1'b1);
    issue("illf", I_ILLF, 32'hCC, 32'hDD, 4'b1111, 32'hCC, 32'hDD, 1'b1);

    // Backpressure: A held, B skidded, C waits.
    ex_ready = 1'b0;
    send(I_ADD, 32'd11, 32'd1);
    send(I_SUB, 32'd22, 32'd2);
    id_valid = 1'b1; id_instr = I_OR; id_rs_data = 32'd33; id_rt_data = 32'd3;
    @(negedge clk);
    chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
    chk("bp_hold_a", ex_in_0, 32'd11);
    @(posedge clk); #1 ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_a", ex_in_0, 32'd11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_then_b", ex_in_0, 32'd22);
    chk("bp_ready_back", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1 id_valid = 1'b0;
    @(negedge clk);
    chk("bp_then_c", ex_in_0, 32'd33);
    chk("bp_c_ctrl", {28'd0, ex_ctrl}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;

    // Flush with both entries full and a concurrent input.
    ex_ready = 1'b0;
    send(I_ADD, 32'd44, 32'd4);
    send(I_SUB, 32'd55, 32'd5);
    id_valid = 1'b1; id_instr = I_OR; id_rs_data = 32'd66; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_dropped", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;

    // Async reset mid-stream.
    send(I_ADD, 32'd77, 32'd7);
    send(I_SUB, 32'd88, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("ar_ctrl", {28'd0, ex_ctrl}, 32'd0);
    chk("ar_in_0", ex_in_0, 32'd0);
    chk("ar_in_1", ex_in_1, 32'd0);
    chk("ar_illegal", {31'd0, ex_illegal}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ar_id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;

    // Random valid/ready throttling, occasional flush.
    for (int c = 0; c < 400; c++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      ex_ready   = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      id_instr   = rnd_instr();
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      @(posedge clk); #1;
    end
    id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
